// File: rtl/bcd_counter_9999.sv
// Four-digit BCD event counter (0000-9999) advanced by rising edges of a slow
// tick that is sampled as data, synchronised and prescaled by STEP_DIV.
module bcd_counter_9999 #(
    parameter int SYNC_STAGES = 2,
    parameter int STEP_DIV    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        run,
    input  logic        up,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] bcd,
    output logic        wrap,
    output logic        step_o
);

    localparam logic [9:0] PRESC_MAX = 10'(STEP_DIV - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [9:0]             presc_q;
    logic [9:0]             presc_d;
    logic [15:0]            bcd_q;
    logic [15:0]            bcd_d;
    logic [15:0]            bcd_step;
    logic [15:0]            bcd_clamp;
    logic                   wrap_q;
    logic                   wrap_d;
    logic                   step_q;
    logic                   step_d;
    logic                   tick_edge;
    logic                   qual;
    logic                   step;
    logic                   carry;

    // The synchroniser and edge history run regardless of run/clr/load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign qual      = tick_edge & run;
    assign step      = qual & (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        if (clr || load) begin
            presc_d = '0;
        end else if (qual) begin
            presc_d = step ? 10'd0 : presc_q + 10'd1;
        end
    end

    // Ripple one unit through the digits; carry out of the top digit is the wrap.
    always_comb begin
        bcd_step  = bcd_q;
        bcd_clamp = '0;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bcd_clamp[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (bcd_q[4*i +: 4] == 4'd9) begin
                        bcd_step[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_step[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (bcd_q[4*i +: 4] == 4'd0) begin
                        bcd_step[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_step[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        step_d = 1'b0;
        if (clr) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d = bcd_clamp;
        end else if (step) begin
            bcd_d  = bcd_step;
            wrap_d = carry;
            step_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            bcd_q   <= '0;
            wrap_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            wrap_q  <= wrap_d;
            step_q  <= step_d;
        end
    end

    assign bcd    = bcd_q;
    assign wrap   = wrap_q;
    assign step_o = step_q;

endmodule

// File: tb/tb_bcd_counter_9999.sv
// Bench for bcd_counter_9999: two instances (STEP_DIV=1 and 10) share stimulus
// and are checked against an integer-valued count model.
module tb_bcd_counter_9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        run = 1'b1;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] bcd1, bcd10;
    logic        wrap1, wrap10, step1, step10;

    int vectors = 0;
    int miscompares = 0;
    int n_step1 = 0, n_step10 = 0, n_wrap1 = 0, n_wrap10 = 0;
    int m1 = 0, m10 = 0, p10 = 0;
    int e_step1 = 0, e_step10 = 0, e_wrap1 = 0, e_wrap10 = 0;
    int snap;

    typedef struct {
        logic        clr;
        logic        load;
        logic [15:0] load_val;
        logic [15:0] exp_bcd;
    } vec_t;
    vec_t vecs[8];

    bcd_counter_9999 #(.SYNC_STAGES(2), .STEP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .up(up), .clr(clr),
        .load(load), .load_val(load_val), .bcd(bcd1), .wrap(wrap1), .step_o(step1)
    );

    bcd_counter_9999 #(.SYNC_STAGES(2), .STEP_DIV(10)) dut10 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .up(up), .clr(clr),
        .load(load), .load_val(load_val), .bcd(bcd10), .wrap(wrap10), .step_o(step10)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (step1)  n_step1  <= n_step1 + 1;
        if (step10) n_step10 <= n_step10 + 1;
        if (wrap1)  n_wrap1  <= n_wrap1 + 1;
        if (wrap10) n_wrap10 <= n_wrap10 + 1;
    end

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(logic [15:0] v);
        int r;
        int d;
        r = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One count step on the model: modular arithmetic on 0..9999.
    task automatic model_step(inout int c, inout int ns, inout int nw);
        ns++;
        if (up) begin
            if (c == 9999) nw++;
            c = (c + 1) % 10000;
        end else begin
            if (c == 0) nw++;
            c = (c + 9999) % 10000;
        end
    endtask

    task automatic model_tick();
        if (run) begin
            model_step(m1, e_step1, e_wrap1);
            p10++;
            if (p10 == 10) begin
                p10 = 0;
                model_step(m10, e_step10, e_wrap10);
            end
        end
    endtask

    task automatic check_all(input string name);
        @(negedge clk);
        check({name, ".bcd1"}, 32'(bcd1), 32'(to_bcd(m1)));
        check({name, ".bcd10"}, 32'(bcd10), 32'(to_bcd(m10)));
        check({name, ".steps1"}, n_step1, e_step1);
        check({name, ".steps10"}, n_step10, e_step10);
        check({name, ".wraps1"}, n_wrap1, e_wrap1);
        check({name, ".wraps10"}, n_wrap10, e_wrap10);
    endtask

    // Tick high ~5 cycles then low 4; optionally checks step_o lands on the 3rd edge.
    task automatic tick_pulse(input bit chk);
        @(posedge clk); #1 tick = 1'b1;
        repeat (3) @(negedge clk);
        if (chk) check("lat.early", 32'(step1), 32'd0);
        @(negedge clk);
        if (chk) check("lat.on", 32'(step1), 32'(run));
        @(negedge clk);
        if (chk) check("lat.width", 32'(step1), 32'd0);
        @(posedge clk); #1 tick = 1'b0;
        repeat (4) @(posedge clk);
        model_tick();
    endtask

    task automatic apply_ctl(input logic c, input logic l, input logic [15:0] v);
        @(posedge clk); #1 clr = c; load = l; load_val = v;
        @(posedge clk); #1 clr = 1'b0; load = 1'b0;
        m1 = c ? 0 : clamp_val(v);
        m10 = m1;
        p10 = 0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'hA5F3, 16'h9593};
        vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 16'h9999};
        vecs[2] = '{1'b0, 1'b1, 16'h1234, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 16'h5555, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 16'h0A9C, 16'h0999};
        vecs[5] = '{1'b0, 1'b1, 16'h8F0B, 16'h8909};
        vecs[6] = '{1'b1, 1'b1, 16'h4321, 16'h0000};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.bcd", 32'(bcd1), 32'h0);
        check("rst.wrap", 32'(wrap1), 32'h0);
        check("rst.step", 32'(step1), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Twelve steps up from reset.
        for (int i = 0; i < 12; i++) tick_pulse(1'b1);
        check_all("up12");
        check("up12.bcd", 32'(bcd1), 32'h0012);
        check("up12.nstep", n_step1, 12);
        check("up12.nwrap", n_wrap1, 0);

        for (int i = 0; i < 8; i++) begin
            apply_ctl(vecs[i].clr, vecs[i].load, vecs[i].load_val);
            @(negedge clk);
            check($sformatf("tbl%0d.bcd1", i), 32'(bcd1), 32'(vecs[i].exp_bcd));
            check($sformatf("tbl%0d.bcd10", i), 32'(bcd10), 32'(vecs[i].exp_bcd));
        end

        // 9998 -> 9999 -> 0000 with wrap.
        apply_ctl(1'b0, 1'b1, 16'h9998);
        tick_pulse(1'b1);
        check_all("wrapup1");
        check("wrapup1.bcd", 32'(bcd1), 32'h9999);
        tick_pulse(1'b1);
        check_all("wrapup2");
        check("wrapup2.bcd", 32'(bcd1), 32'h0000);

        // Down through zero, then borrow through three digits.
        up = 1'b0;
        apply_ctl(1'b1, 1'b0, 16'h0000);
        tick_pulse(1'b1);
        check_all("wrapdn");
        check("wrapdn.bcd", 32'(bcd1), 32'h9999);
        apply_ctl(1'b0, 1'b1, 16'h1000);
        tick_pulse(1'b1);
        check_all("borrow");
        check("borrow.bcd", 32'(bcd1), 32'h0999);

        // Prescaler by 10, including pause and resume.
        up = 1'b1;
        apply_ctl(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 25; i++) tick_pulse(1'b0);
        check_all("div25");
        check("div25.bcd10", 32'(bcd10), 32'h0002);
        run = 1'b0;
        for (int i = 0; i < 7; i++) tick_pulse(1'b0);
        check_all("pause");
        check("pause.bcd10", 32'(bcd10), 32'h0002);
        run = 1'b1;
        for (int i = 0; i < 5; i++) tick_pulse(1'b0);
        check_all("resume");
        check("resume.bcd10", 32'(bcd10), 32'h0003);

        // clr+load coinciding with a step that would otherwise wrap.
        apply_ctl(1'b0, 1'b1, 16'h9999);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 clr = 1'b1; load = 1'b1; load_val = 16'h4321;
        @(posedge clk); #1 clr = 1'b0; load = 1'b0;
        @(negedge clk);
        check("coin.bcd", 32'(bcd1), 32'h0000);
        check("coin.step", 32'(step1), 32'h0);
        check("coin.wrap", 32'(wrap1), 32'h0);
        m1 = 0; m10 = 0; p10 = 0;
        @(posedge clk); #1 tick = 1'b0;
        repeat (4) @(posedge clk);
        check_all("coin");

        // Reset mid-count with tick held high.
        run = 1'b0;
        @(posedge clk); #1 tick = 1'b1;
        repeat (6) @(posedge clk);
        #1 run = 1'b1;
        apply_ctl(1'b0, 1'b1, 16'h0457);
        repeat (3) @(posedge clk);
        check_all("pre_rst");
        check("pre_rst.bcd", 32'(bcd1), 32'h0457);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst.bcd1", 32'(bcd1), 32'h0000);
        check("mid_rst.bcd10", 32'(bcd10), 32'h0000);
        repeat (2) @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        m1 = 0; m10 = 0; p10 = 0;
        repeat (3) @(negedge clk);
        check("rel.early", 32'(step1), 32'h0);
        @(negedge clk);
        check("rel.step", 32'(step1), 32'h1);
        check("rel.bcd", 32'(bcd1), 32'h0001);
        model_tick();
        snap = e_step1;
        repeat (10) @(posedge clk);
        check_all("rel.hold");
        check("rel.nostep", n_step1, snap);
        #1 tick = 1'b0;
        repeat (4) @(posedge clk);
        tick_pulse(1'b1);
        check_all("rel.again");

        // Random mix of loads, clears, direction and run changes.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: apply_ctl(1'b0, 1'b1, 16'($urandom_range(0, 65535)));
                1: apply_ctl(1'b1, 1'b0, 16'h0000);
                default: begin
                    up  = 1'($urandom_range(0, 1));
                    run = ($urandom_range(0, 3) != 0);
                    tick_pulse(1'b1);
                end
            endcase
            check_all($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
